// File: rtl/nvdla_dbb_burst_bridge.sv
// rtl/nvdla_dbb_burst_bridge.sv - DBB write/read burst to HWPE streamer bridge
// Write path and queued read path share one round-robin start arbiter.
module nvdla_dbb_burst_bridge #(
    parameter int unsigned DW   = 64,
    parameter int unsigned AW   = 32,
    parameter int unsigned IDW  = 8,
    parameter int unsigned LENW = 4,
    parameter int unsigned OTD  = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clear_i,
    input  logic              wr_req_valid_i,
    output logic              wr_req_ready_o,
    input  logic [AW-1:0]     wr_req_addr_i,
    input  logic [LENW-1:0]   wr_req_len_i,
    input  logic [IDW-1:0]    wr_req_id_i,
    input  logic              rd_req_valid_i,
    output logic              rd_req_ready_o,
    input  logic [AW-1:0]     rd_req_addr_i,
    input  logic [LENW-1:0]   rd_req_len_i,
    input  logic [IDW-1:0]    rd_req_id_i,
    input  logic              wr_dat_valid_i,
    output logic              wr_dat_ready_o,
    input  logic [DW-1:0]     wr_dat_data_i,
    input  logic [DW/8-1:0]   wr_dat_strb_i,
    input  logic              wr_dat_last_i,
    output logic              wr_rsp_valid_o,
    input  logic              wr_rsp_ready_i,
    output logic [IDW-1:0]    wr_rsp_id_o,
    output logic              rd_dat_valid_o,
    input  logic              rd_dat_ready_i,
    output logic [DW-1:0]     rd_dat_data_o,
    output logic [IDW-1:0]    rd_dat_id_o,
    output logic              rd_dat_last_o,
    output logic              sink_start_o,
    output logic              src_start_o,
    input  logic              sink_ready_i,
    input  logic              src_ready_i,
    output logic [AW-1:0]     xfer_addr_o,
    output logic [LENW:0]     xfer_beats_o,
    output logic              mem_wr_valid_o,
    input  logic              mem_wr_ready_i,
    output logic [DW-1:0]     mem_wr_data_o,
    output logic [DW/8-1:0]   mem_wr_strb_o,
    input  logic              mem_rd_valid_i,
    output logic              mem_rd_ready_o,
    input  logic [DW-1:0]     mem_rd_data_i,
    output logic              err_o
);

    localparam int unsigned PW = $clog2(OTD);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(OTD);
    localparam logic [LENW:0] ONE_BEAT = (LENW+1)'(1);

    typedef enum logic [1:0] {W_IDLE, W_START, W_DATA, W_RESP} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA} r_state_t;

    w_state_t        w_st;
    r_state_t        r_st;
    logic [AW-1:0]   w_addr;
    logic [LENW-1:0] w_len, wcnt, r_len, rcnt;
    logic [IDW-1:0]  w_id, r_id;
    logic            err_q, prio_wr;

    logic [AW-1:0]   q_addr [OTD];
    logic [LENW-1:0] q_len  [OTD];
    logic [IDW-1:0]  q_id   [OTD];
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   q_cnt;

    logic w_req, r_req, w_gnt, r_gnt;
    logic w_data, r_data, w_beat, r_beat, w_last, r_last;
    logic q_full, q_empty, push, pop;

    assign q_full  = (q_cnt == FULL_CNT);
    assign q_empty = (q_cnt == '0);
    assign push    = rd_req_valid_i && !q_full;
    assign pop     = r_gnt;

    // Round-robin only matters when both paths want a start in the same cycle.
    assign w_req = (w_st == W_START) && sink_ready_i;
    assign r_req = (r_st == R_START) && src_ready_i;
    assign w_gnt = w_req && (!r_req || prio_wr);
    assign r_gnt = r_req && (!w_req || !prio_wr);

    assign w_data = (w_st == W_DATA);
    assign r_data = (r_st == R_DATA);
    assign w_last = (wcnt == w_len);
    assign r_last = (rcnt == r_len);
    assign w_beat = w_data && wr_dat_valid_i && mem_wr_ready_i;
    assign r_beat = r_data && mem_rd_valid_i && rd_dat_ready_i;

    assign wr_req_ready_o = (w_st == W_IDLE);
    assign rd_req_ready_o = !q_full;
    assign sink_start_o   = w_gnt;
    assign src_start_o    = r_gnt;
    assign mem_wr_valid_o = w_data && wr_dat_valid_i;
    assign wr_dat_ready_o = w_data && mem_wr_ready_i;
    assign mem_wr_data_o  = wr_dat_data_i;
    assign mem_wr_strb_o  = wr_dat_strb_i;
    assign wr_rsp_valid_o = (w_st == W_RESP);
    assign wr_rsp_id_o    = w_id;
    assign rd_dat_valid_o = r_data && mem_rd_valid_i;
    assign mem_rd_ready_o = r_data && rd_dat_ready_i;
    assign rd_dat_data_o  = mem_rd_data_i;
    assign rd_dat_id_o    = r_id;
    assign rd_dat_last_o  = r_data && r_last;
    assign err_o          = err_q;

    always_comb begin
        xfer_addr_o  = '0;
        xfer_beats_o = '0;
        if (w_gnt) begin
            xfer_addr_o  = w_addr;
            xfer_beats_o = {1'b0, w_len} + ONE_BEAT;
        end else if (r_gnt) begin
            xfer_addr_o  = q_addr[rd_ptr];
            xfer_beats_o = {1'b0, q_len[rd_ptr]} + ONE_BEAT;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            w_st <= W_IDLE; w_addr <= '0; w_len <= '0; w_id <= '0; wcnt <= '0; err_q <= 1'b0;
        end else if (clear_i) begin
            w_st <= W_IDLE; w_addr <= '0; w_len <= '0; w_id <= '0; wcnt <= '0; err_q <= 1'b0;
        end else begin
            // The master's last flag is only audited; the beat counter decides the burst end.
            if (w_beat && (wr_dat_last_i != w_last)) err_q <= 1'b1;
            case (w_st)
                W_IDLE: if (wr_req_valid_i) begin
                    w_addr <= wr_req_addr_i;
                    w_len  <= wr_req_len_i;
                    w_id   <= wr_req_id_i;
                    wcnt   <= '0;
                    w_st   <= W_START;
                end
                W_START: if (w_gnt) w_st <= W_DATA;
                W_DATA: if (w_beat) begin
                    if (w_last) w_st <= W_RESP;
                    else        wcnt <= wcnt + LENW'(1);
                end
                W_RESP: if (wr_rsp_ready_i) w_st <= W_IDLE;
                default: w_st <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_st <= R_IDLE; r_len <= '0; r_id <= '0; rcnt <= '0;
            wr_ptr <= '0; rd_ptr <= '0; q_cnt <= '0; prio_wr <= 1'b1;
        end else if (clear_i) begin
            r_st <= R_IDLE; r_len <= '0; r_id <= '0; rcnt <= '0;
            wr_ptr <= '0; rd_ptr <= '0; q_cnt <= '0; prio_wr <= 1'b1;
        end else begin
            if (w_req && r_req) prio_wr <= !prio_wr;
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            q_cnt <= q_cnt + CW'(push) - CW'(pop);
            case (r_st)
                R_IDLE: if (!q_empty) r_st <= R_START;
                R_START: if (r_gnt) begin
                    r_len <= q_len[rd_ptr];
                    r_id  <= q_id[rd_ptr];
                    rcnt  <= '0;
                    r_st  <= R_DATA;
                end
                R_DATA: if (r_beat) begin
                    if (r_last) r_st <= q_empty ? R_IDLE : R_START;
                    else        rcnt <= rcnt + LENW'(1);
                end
                default: r_st <= R_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            q_addr[wr_ptr] <= rd_req_addr_i;
            q_len[wr_ptr]  <= rd_req_len_i;
            q_id[wr_ptr]   <= rd_req_id_i;
        end
    end

endmodule

// File: tb/tb_nvdla_dbb_burst_bridge.sv
// tb/tb_nvdla_dbb_burst_bridge.sv - randomized bench for nvdla_dbb_burst_bridge
// Transaction-level model: write bursts by beat count, read requests in a queue.
module tb_nvdla_dbb_burst_bridge;
    localparam int DW = 64, AW = 32, IDW = 8, LENW = 4, OTD = 4;

    logic clk, rst, clear;
    logic wr_req_valid, wr_req_ready, rd_req_valid, rd_req_ready;
    logic [AW-1:0] wr_req_addr, rd_req_addr, xfer_addr;
    logic [LENW-1:0] wr_req_len, rd_req_len;
    logic [IDW-1:0] wr_req_id, rd_req_id, wr_rsp_id, rd_dat_id;
    logic wr_dat_valid, wr_dat_ready, wr_dat_last, wr_rsp_valid, wr_rsp_ready;
    logic [DW-1:0] wr_dat_data, rd_dat_data, mem_wr_data, mem_rd_data;
    logic [DW/8-1:0] wr_dat_strb, mem_wr_strb;
    logic rd_dat_valid, rd_dat_ready, rd_dat_last;
    logic sink_start, src_start, sink_ready, src_ready;
    logic [LENW:0] xfer_beats;
    logic mem_wr_valid, mem_wr_ready, mem_rd_valid, mem_rd_ready, err;

    typedef struct {
        logic [AW-1:0]   addr;
        logic [LENW-1:0] len;
        logic [IDW-1:0]  id;
    } req_t;

    req_t rq[$];
    int n_vec = 0, n_err = 0;
    bit m_err = 0;

    nvdla_dbb_burst_bridge #(.DW(DW), .AW(AW), .IDW(IDW), .LENW(LENW), .OTD(OTD)) dut (
        .clk_i(clk), .rst_i(rst), .clear_i(clear),
        .wr_req_valid_i(wr_req_valid), .wr_req_ready_o(wr_req_ready),
        .wr_req_addr_i(wr_req_addr), .wr_req_len_i(wr_req_len), .wr_req_id_i(wr_req_id),
        .rd_req_valid_i(rd_req_valid), .rd_req_ready_o(rd_req_ready),
        .rd_req_addr_i(rd_req_addr), .rd_req_len_i(rd_req_len), .rd_req_id_i(rd_req_id),
        .wr_dat_valid_i(wr_dat_valid), .wr_dat_ready_o(wr_dat_ready), .wr_dat_data_i(wr_dat_data),
        .wr_dat_strb_i(wr_dat_strb), .wr_dat_last_i(wr_dat_last),
        .wr_rsp_valid_o(wr_rsp_valid), .wr_rsp_ready_i(wr_rsp_ready), .wr_rsp_id_o(wr_rsp_id),
        .rd_dat_valid_o(rd_dat_valid), .rd_dat_ready_i(rd_dat_ready), .rd_dat_data_o(rd_dat_data),
        .rd_dat_id_o(rd_dat_id), .rd_dat_last_o(rd_dat_last),
        .sink_start_o(sink_start), .src_start_o(src_start),
        .sink_ready_i(sink_ready), .src_ready_i(src_ready),
        .xfer_addr_o(xfer_addr), .xfer_beats_o(xfer_beats),
        .mem_wr_valid_o(mem_wr_valid), .mem_wr_ready_i(mem_wr_ready),
        .mem_wr_data_o(mem_wr_data), .mem_wr_strb_o(mem_wr_strb),
        .mem_rd_valid_i(mem_rd_valid), .mem_rd_ready_o(mem_rd_ready), .mem_rd_data_i(mem_rd_data),
        .err_o(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle_inputs();
        wr_req_valid = 0; wr_req_addr = '0; wr_req_len = '0; wr_req_id = '0;
        rd_req_valid = 0; rd_req_addr = '0; rd_req_len = '0; rd_req_id = '0;
        wr_dat_valid = 0; wr_dat_data = '0; wr_dat_strb = '0; wr_dat_last = 0;
        wr_rsp_ready = 0; rd_dat_ready = 0; sink_ready = 0; src_ready = 0;
        mem_wr_ready = 0; mem_rd_valid = 0; mem_rd_data = '0;
    endtask

    task automatic test_reset();
        idle_inputs(); clear = 0; rst = 1;
        @(negedge clk); #1;
        n_vec++; if (sink_start !== 0 || src_start !== 0) begin n_err++; $display("FAIL reset_starts: got %b%b exp 00", sink_start, src_start); end
        n_vec++; if (mem_wr_valid !== 0 || rd_dat_valid !== 0 || wr_rsp_valid !== 0) begin n_err++; $display("FAIL reset_valids: got %b%b%b exp 000", mem_wr_valid, rd_dat_valid, wr_rsp_valid); end
        n_vec++; if (wr_dat_ready !== 0 || mem_rd_ready !== 0 || rd_dat_last !== 0) begin n_err++; $display("FAIL reset_readies: got %b%b%b exp 000", wr_dat_ready, mem_rd_ready, rd_dat_last); end
        n_vec++; if (err !== 0) begin n_err++; $display("FAIL reset_err: got %b exp 0", err); end
        @(negedge clk); rst = 0; #1;
        n_vec++; if (wr_req_ready !== 1 || rd_req_ready !== 1) begin n_err++; $display("FAIL reset_req_ready: got %b%b exp 11", wr_req_ready, rd_req_ready); end
        m_err = 0; rq.delete();
    endtask

    // One write burst with random handshake gaps; last_k is the beat carrying wr_dat_last.
    task automatic do_write(input logic [AW-1:0] a, input logic [LENW-1:0] l,
                            input logic [IDW-1:0] id, input int last_k);
        int beats, sent, mem_beats, starts, cyc;
        bit req_done, started, rsp_done, data_ph, rsp_ph, start_ph;
        beats = int'(l) + 1; sent = 0; mem_beats = 0; starts = 0; cyc = 0;
        req_done = 0; started = 0; rsp_done = 0;
        if (last_k != beats) m_err = 1;
        while (!rsp_done && cyc < 400) begin
            @(negedge clk); cyc++;
            data_ph = started && sent < beats; rsp_ph = (sent == beats); start_ph = req_done && !started;
            wr_req_valid = !req_done; wr_req_addr = a; wr_req_len = l; wr_req_id = id;
            sink_ready = 1'($urandom_range(0, 1));
            wr_dat_valid = (sent < beats) && ($urandom_range(0, 3) != 0);
            wr_dat_data = {$urandom, $urandom}; wr_dat_strb = 8'($urandom);
            wr_dat_last = (sent + 1 == last_k);
            mem_wr_ready = ($urandom_range(0, 3) != 0);
            wr_rsp_ready = 1'($urandom_range(0, 1));
            #1;
            n_vec++; if (sink_start !== (start_ph && sink_ready)) begin n_err++; $display("FAIL wr_sink_start: got %b exp %b", sink_start, start_ph && sink_ready); end
            if (sink_start && start_ph) begin
                n_vec++; if (xfer_addr !== a) begin n_err++; $display("FAIL wr_xfer_addr: got %h exp %h", xfer_addr, a); end
                n_vec++; if (xfer_beats !== (LENW+1)'(beats)) begin n_err++; $display("FAIL wr_xfer_beats: got %0d exp %0d", xfer_beats, beats); end
            end
            n_vec++; if (mem_wr_valid !== (data_ph && wr_dat_valid)) begin n_err++; $display("FAIL wr_mem_valid: got %b exp %b", mem_wr_valid, data_ph && wr_dat_valid); end
            n_vec++; if (wr_dat_ready !== (data_ph && mem_wr_ready)) begin n_err++; $display("FAIL wr_dat_ready: got %b exp %b", wr_dat_ready, data_ph && mem_wr_ready); end
            if (data_ph && wr_dat_valid) begin
                n_vec++; if (mem_wr_data !== wr_dat_data || mem_wr_strb !== wr_dat_strb) begin n_err++; $display("FAIL wr_mem_data: got %h/%h exp %h/%h", mem_wr_data, mem_wr_strb, wr_dat_data, wr_dat_strb); end
            end
            n_vec++; if (wr_rsp_valid !== rsp_ph) begin n_err++; $display("FAIL wr_rsp_valid: got %b exp %b", wr_rsp_valid, rsp_ph); end
            if (rsp_ph) begin
                n_vec++; if (wr_rsp_id !== id) begin n_err++; $display("FAIL wr_rsp_id: got %h exp %h", wr_rsp_id, id); end
            end
            if (wr_req_valid && wr_req_ready) req_done = 1;
            if (sink_start) begin starts++; started = 1; end
            if (data_ph && wr_dat_valid && mem_wr_ready) sent++;
            if (mem_wr_valid && mem_wr_ready) mem_beats++;
            if (rsp_ph && wr_rsp_ready) rsp_done = 1;
        end
        n_vec++; if (!rsp_done) begin n_err++; $display("FAIL wr_timeout: got %0d beats exp %0d", sent, beats); end
        n_vec++; if (starts !== 1) begin n_err++; $display("FAIL wr_start_count: got %0d exp 1", starts); end
        n_vec++; if (mem_beats !== beats) begin n_err++; $display("FAIL wr_mem_beats: got %0d exp %0d", mem_beats, beats); end
        @(negedge clk); idle_inputs(); #1;
        n_vec++; if (err !== m_err) begin n_err++; $display("FAIL wr_err: got %b exp %b", err, m_err); end
    endtask

    task automatic push_rd(input logic [AW-1:0] a, input logic [LENW-1:0] l,
                           input logic [IDW-1:0] id, input bit exp_acc);
        req_t r;
        @(negedge clk);
        rd_req_valid = 1; rd_req_addr = a; rd_req_len = l; rd_req_id = id; src_ready = 0;
        #1;
        n_vec++; if (rd_req_ready !== exp_acc) begin n_err++; $display("FAIL rd_push_ready id %h: got %b exp %b", id, rd_req_ready, exp_acc); end
        n_vec++; if (src_start !== 0) begin n_err++; $display("FAIL rd_push_start: got %b exp 0", src_start); end
        if (rd_req_ready) begin r.addr = a; r.len = l; r.id = id; rq.push_back(r); end
    endtask

    // Serves the modelled read queue (and pushes n_new random requests) until everything drains.
    task automatic run_reads(input int n_new, input bit toggle, output int beats);
        bit active, act0, tog;
        logic [LENW-1:0] a_len;
        logic [IDW-1:0] a_id;
        int rcnt, pushed, cyc;
        req_t r;
        active = 0; tog = 0; a_len = '0; a_id = '0; rcnt = 0; pushed = 0; cyc = 0; beats = 0;
        while ((pushed < n_new || rq.size() > 0 || active) && cyc < 3000) begin
            @(negedge clk); cyc++; act0 = active;
            rd_req_valid = (pushed < n_new) && ($urandom_range(0, 1) == 1);
            rd_req_addr = $urandom; rd_req_id = IDW'($urandom);
            rd_req_len = ($urandom_range(0, 5) == 0) ? LENW'(15) : LENW'($urandom_range(0, 4));
            src_ready = 1'($urandom_range(0, 1));
            tog = !tog;
            mem_rd_valid = toggle ? 1'b1 : 1'($urandom_range(0, 1));
            rd_dat_ready = toggle ? tog : ($urandom_range(0, 3) != 0);
            mem_rd_data = {$urandom, $urandom};
            #1;
            n_vec++; if (rd_req_ready !== (rq.size() < OTD)) begin n_err++; $display("FAIL rd_req_ready: got %b exp %b", rd_req_ready, rq.size() < OTD); end
            n_vec++; if (rd_dat_valid !== (act0 && mem_rd_valid)) begin n_err++; $display("FAIL rd_dat_valid: got %b exp %b", rd_dat_valid, act0 && mem_rd_valid); end
            n_vec++; if (mem_rd_ready !== (act0 && rd_dat_ready)) begin n_err++; $display("FAIL rd_mem_ready: got %b exp %b", mem_rd_ready, act0 && rd_dat_ready); end
            n_vec++; if (rd_dat_last !== (act0 && rcnt == int'(a_len))) begin n_err++; $display("FAIL rd_last: got %b exp %b beat %0d", rd_dat_last, act0 && rcnt == int'(a_len), rcnt); end
            n_vec++; if (sink_start !== 0) begin n_err++; $display("FAIL rd_sink_start: got %b exp 0", sink_start); end
            if (act0) begin
                n_vec++; if (rd_dat_id !== a_id) begin n_err++; $display("FAIL rd_id: got %h exp %h", rd_dat_id, a_id); end
                if (mem_rd_valid) begin
                    n_vec++; if (rd_dat_data !== mem_rd_data) begin n_err++; $display("FAIL rd_data: got %h exp %h", rd_dat_data, mem_rd_data); end
                end
            end
            if (src_start) begin
                n_vec++; if (act0 || rq.size() == 0) begin n_err++; $display("FAIL rd_spurious_start: got active %b queued %0d exp 0/>0", act0, rq.size()); end
                if (rq.size() > 0) begin
                    n_vec++; if (xfer_addr !== rq[0].addr) begin n_err++; $display("FAIL rd_xfer_addr: got %h exp %h", xfer_addr, rq[0].addr); end
                    n_vec++; if (xfer_beats !== ({1'b0, rq[0].len} + 5'd1)) begin n_err++; $display("FAIL rd_xfer_beats: got %0d exp %0d", xfer_beats, rq[0].len + 1); end
                end
            end
            if (act0 && mem_rd_valid && rd_dat_ready) begin
                beats++;
                if (rcnt == int'(a_len)) active = 0; else rcnt++;
            end
            if (src_start && !act0 && rq.size() > 0) begin
                r = rq.pop_front(); active = 1; a_len = r.len; a_id = r.id; rcnt = 0;
            end
            if (rd_req_valid && rd_req_ready) begin
                r.addr = rd_req_addr; r.len = rd_req_len; r.id = rd_req_id; rq.push_back(r); pushed++;
            end
        end
        n_vec++; if (cyc >= 3000) begin n_err++; $display("FAIL rd_timeout: got %0d queued exp 0", rq.size()); end
        @(negedge clk); idle_inputs();
    endtask

    task automatic test_write();
        int b;
        do_write(32'h100, 4'd3, 8'h5A, 4);
        do_write(32'hABC0, 4'd15, 8'hF0, 16);
        for (int i = 0; i < 6; i++) begin
            b = $urandom_range(1, 6);
            do_write($urandom, LENW'(b - 1), IDW'($urandom), b);
        end
    endtask

    task automatic test_write_last_err();
        do_write(32'h400, 4'd3, 8'h33, 2);
        do_write(32'h500, 4'd1, 8'h34, 2);
        @(negedge clk); clear = 1;
        @(negedge clk); clear = 0; #1;
        n_vec++; if (err !== 0) begin n_err++; $display("FAIL clear_err: got %b exp 0", err); end
        m_err = 0;
        do_write(32'h600, 4'd2, 8'h35, 3);
    endtask

    task automatic test_rd_queue_full();
        int b;
        idle_inputs();
        for (int k = 1; k <= 5; k++)
            push_rd(32'h1000 * k, LENW'(k - 1), IDW'(k), k <= OTD);
        run_reads(0, 0, b);
        n_vec++; if (b !== 10) begin n_err++; $display("FAIL rd_queue_beats: got %0d exp 10", b); end
        run_reads(12, 0, b);
    endtask

    task automatic test_contention();
        bit wf;
        for (int rnd = 0; rnd < 2; rnd++) begin
            wf = (rnd == 0);
            @(negedge clk); idle_inputs();
            wr_req_valid = 1; wr_req_addr = 32'h2000 + rnd; wr_req_id = IDW'(8'h10 + rnd);
            rd_req_valid = 1; rd_req_addr = 32'h3000 + rnd; rd_req_id = IDW'(8'h20 + rnd);
            #1;
            n_vec++; if (wr_req_ready !== 1 || rd_req_ready !== 1) begin n_err++; $display("FAIL cont_req_ready: got %b%b exp 11", wr_req_ready, rd_req_ready); end
            @(negedge clk); wr_req_valid = 0; rd_req_valid = 0;
            repeat (2) @(negedge clk);
            sink_ready = 1; src_ready = 1; #1;
            n_vec++; if (sink_start !== wf || src_start !== !wf) begin n_err++; $display("FAIL cont_first_%0d: got %b%b exp %b%b", rnd, sink_start, src_start, wf, !wf); end
            n_vec++; if (xfer_addr !== (wf ? 32'h2000 : 32'h3000) + rnd) begin n_err++; $display("FAIL cont_addr1_%0d: got %h", rnd, xfer_addr); end
            @(negedge clk); #1;
            n_vec++; if (sink_start !== !wf || src_start !== wf) begin n_err++; $display("FAIL cont_second_%0d: got %b%b exp %b%b", rnd, sink_start, src_start, !wf, wf); end
            n_vec++; if (xfer_addr !== (wf ? 32'h3000 : 32'h2000) + rnd || xfer_beats !== 5'd1) begin n_err++; $display("FAIL cont_addr2_%0d: got %h/%0d", rnd, xfer_addr, xfer_beats); end
            @(negedge clk); sink_ready = 0; src_ready = 0;
            wr_dat_valid = 1; wr_dat_last = 1; mem_wr_ready = 1; mem_rd_valid = 1; rd_dat_ready = 1; #1;
            n_vec++; if (mem_wr_valid !== 1 || rd_dat_valid !== 1 || rd_dat_last !== 1) begin n_err++; $display("FAIL cont_data_%0d: got %b%b%b exp 111", rnd, mem_wr_valid, rd_dat_valid, rd_dat_last); end
            n_vec++; if (rd_dat_id !== IDW'(8'h20 + rnd)) begin n_err++; $display("FAIL cont_rd_id_%0d: got %h", rnd, rd_dat_id); end
            @(negedge clk); idle_inputs(); wr_rsp_ready = 1; #1;
            n_vec++; if (wr_rsp_valid !== 1 || wr_rsp_id !== IDW'(8'h10 + rnd)) begin n_err++; $display("FAIL cont_rsp_%0d: got %b/%h", rnd, wr_rsp_valid, wr_rsp_id); end
            @(negedge clk); idle_inputs(); #1;
            n_vec++; if (wr_rsp_valid !== 0 || rd_dat_valid !== 0) begin n_err++; $display("FAIL cont_idle_%0d: got %b%b exp 00", rnd, wr_rsp_valid, rd_dat_valid); end
        end
    endtask

    task automatic test_rd_backpressure();
        int b;
        idle_inputs();
        push_rd(32'h8000, 4'd7, 8'h77, 1);
        run_reads(0, 1, b);
        n_vec++; if (b !== 8) begin n_err++; $display("FAIL rd_bp_beats: got %0d exp 8", b); end
    endtask

    task automatic test_reset_mid_burst();
        int seen;
        idle_inputs();
        for (int k = 0; k < 3; k++) push_rd(32'h9000 + k, 4'd7, IDW'(8'h61 + k), 1);
        @(negedge clk); rd_req_valid = 0; src_ready = 1; mem_rd_valid = 1; rd_dat_ready = 1;
        seen = 0;
        for (int c = 0; c < 20 && seen < 2; c++) begin
            @(negedge clk); #1;
            if (rd_dat_valid) seen++;
        end
        n_vec++; if (seen !== 2) begin n_err++; $display("FAIL rst_mid_setup: got %0d beats exp 2", seen); end
        #2; rst = 1; #1;
        n_vec++; if (rd_dat_valid !== 0 || mem_rd_ready !== 0 || rd_dat_last !== 0) begin n_err++; $display("FAIL rst_mid_valids: got %b%b%b exp 000", rd_dat_valid, mem_rd_ready, rd_dat_last); end
        n_vec++; if (src_start !== 0 || sink_start !== 0) begin n_err++; $display("FAIL rst_mid_starts: got %b%b exp 00", src_start, sink_start); end
        @(negedge clk); rst = 0; rq.delete(); m_err = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk); #1;
            n_vec++; if (rd_req_ready !== 1 || src_start !== 0 || rd_dat_valid !== 0) begin n_err++; $display("FAIL rst_mid_after_%0d: got ready %b start %b valid %b exp 1 0 0", c, rd_req_ready, src_start, rd_dat_valid); end
        end
        @(negedge clk); idle_inputs();
    endtask

    initial begin
        test_reset();
        test_write();
        test_write_last_err();
        test_rd_queue_full();
        test_contention();
        test_rd_backpressure();
        test_reset_mid_burst();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish exp finish");
        $fatal(1);
    end

endmodule
